// File: rtl/iter_div_axis.sv
// Radix-2 restoring divider with AXI-stream style operand and result channels.
// Returns {quotient, remainder} a fixed WIDTH+2 cycles after acceptance.
module iter_div_axis #(
    parameter bit          SIGNED = 1'b1,
    parameter int unsigned WIDTH  = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0]   dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d;

    logic                 accept;
    logic                 dvd_sign, dvs_sign;
    logic [WIDTH-1:0]     dvd_abs, dvs_abs;
    logic [WIDTH:0]       rem_shift;
    logic                 rem_ge;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign s_axis_divisor_tready  = (state_q == StIdle);
    assign s_axis_dividend_tready = (state_q == StIdle);
    assign m_axis_dout_tvalid     = dout_vld_q;
    assign m_axis_dout_tdata      = dout_q;

    assign accept = (state_q == StIdle) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;

    // |most-negative| wraps to itself, which is the correct unsigned magnitude.
    assign dvd_sign = SIGNED && s_axis_dividend_tdata[WIDTH-1];
    assign dvs_sign = SIGNED && s_axis_divisor_tdata[WIDTH-1];
    assign dvd_abs  = dvd_sign ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign dvs_abs  = dvs_sign ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

    // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom.
    assign rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});

    assign quo_fix = q_neg_q ? -dvd_q : dvd_q;
    assign rem_fix = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    dvd_d   = dvd_abs;
                    dvs_d   = dvs_abs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    q_neg_d = dvd_sign ^ dvs_sign;
                    r_neg_d = dvd_sign;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                rem_d = rem_ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
                dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                dout_d     = {quo_fix, rem_fix};
                dout_vld_d = 1'b1;
                state_d    = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

endmodule
